// File: rtl/bg_endgame_pkg.sv
// Shared constants and FSM state encoding for the end-game background fetch path.
// No logic. No latency. No backpressure.
package bg_endgame_pkg;

    localparam logic [3:0] BLACK_INDEX = 4'h5;
    localparam int         SCREEN_W    = 640;
    localparam int         SCREEN_H    = 480;

    typedef enum logic [1:0] {
        IDLE,
        REVEAL,
        DONE
    } state_t;

endpackage

// File: rtl/bg_endgame_reveal_fsm.sv
// Reveal wipe: counts revealed screen rows, one band per frame start after the end-game pulse.
// reveal_rows_o and reveal_done_o update on the clock edge that ends the frame-start cycle.
// No backpressure; the start pulse is ignored outside IDLE.
module bg_endgame_reveal_fsm
    import bg_endgame_pkg::*;
#(
    parameter int REVEAL_STEP = 8,
    parameter int FULL_ROWS   = SCREEN_H
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    input  logic       start_i,
    output logic [9:0] reveal_rows_o,
    output logic       reveal_done_o
);

    state_t      state_q, state_d;
    logic [9:0]  rows_q, rows_d;
    logic [10:0] rows_sum;
    logic        frame_start;

    assign frame_start = (draw_x_i == 10'd0) && (draw_y_i == 10'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        rows_sum = {1'b0, rows_q} + 11'(REVEAL_STEP);
        unique case (state_q)
            IDLE: begin
                rows_d = '0;
                // A start coinciding with a frame start only arms the wipe.
                if (start_i) state_d = REVEAL;
            end
            REVEAL: begin
                if (frame_start) begin
                    if (rows_sum >= 11'(FULL_ROWS)) begin
                        rows_d  = 10'(FULL_ROWS);
                        state_d = DONE;
                    end else begin
                        rows_d = rows_sum[9:0];
                    end
                end
            end
            DONE:    rows_d = 10'(FULL_ROWS);
            default: begin
                state_d = IDLE;
                rows_d  = '0;
            end
        endcase
    end

    assign reveal_rows_o = rows_q;
    assign reveal_done_o = (state_q == DONE);

endmodule

// File: rtl/background_endgame_fetch.sv
// End-game background fetch: VGA coords -> 2x-upscaled ROM address -> colour index; reveal wipe under BG_ENDGAME_REVEAL_EN.
// Latency 3 cycles (address t+1, ROM data t+2, pix_index/pix_valid t+3), fully pipelined.
// No backpressure: one pixel accepted and one produced every cycle, never stalls.
module background_endgame_fetch
    import bg_endgame_pkg::*;
#(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int REVEAL_STEP = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              active,
    input  logic              endgame_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic              reveal_done
);

    logic [9:0]        row_s, col_s;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              act1_q, act2_q;
    logic [9:0]        y1_q, y2_q;
    logic [3:0]        pix_q;
    logic              vld_q;
    logic              revealed;

    assign row_s = DrawY >> SCALE_SHIFT;
    assign col_s = DrawX >> SCALE_SHIFT;

    // Out-of-image coordinates read address 0 so the ROM never sees an out-of-range address.
    always_comb begin
        addr_d = '0;
        if (active && (row_s < 10'(IMG_H)) && (col_s < 10'(IMG_W)))
            addr_d = ADDR_W'(row_s) * ADDR_W'(IMG_W) + ADDR_W'(col_s);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            act1_q <= 1'b0;
            act2_q <= 1'b0;
            y1_q   <= '0;
            y2_q   <= '0;
            pix_q  <= BLACK_INDEX;
            vld_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            act1_q <= active;
            y1_q   <= DrawY;
            act2_q <= act1_q;
            y2_q   <= y1_q;
            vld_q  <= act2_q;
            pix_q  <= (act2_q && revealed) ? rom_q : BLACK_INDEX;
        end
    end

`ifdef BG_ENDGAME_REVEAL_EN
    logic [9:0] reveal_rows;

    bg_endgame_reveal_fsm #(
        .REVEAL_STEP (REVEAL_STEP),
        .FULL_ROWS   (IMG_H << SCALE_SHIFT)
    ) u_reveal_fsm (
        .clk_i         (vga_clk),
        .rst_n_i       (reset_n),
        .draw_x_i      (DrawX),
        .draw_y_i      (DrawY),
        .start_i       (endgame_start),
        .reveal_rows_o (reveal_rows),
        .reveal_done_o (reveal_done)
    );

    // Compare against the row aligned with the ROM data, not the live DrawY.
    assign revealed = (y2_q < reveal_rows);
`else
    logic unused_cfg;

    assign revealed    = 1'b1;
    assign reveal_done = 1'b1;
    assign unused_cfg  = ^{endgame_start, y2_q, 1'(REVEAL_STEP)};
`endif

    assign rom_addr  = addr_q;
    assign pix_index = pix_q;
    assign pix_valid = vld_q;

endmodule

// File: tb/tb_background_endgame_fetch.sv
// Bench for background_endgame_fetch: address table, scoreboarded pixel stream, reset and reveal sequences.
module tb_background_endgame_fetch;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        active, endgame_start;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        reveal_done;

    always #5 vga_clk = ~vga_clk;

    background_endgame_fetch dut (
        .vga_clk       (vga_clk),
        .reset_n       (reset_n),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .active        (active),
        .endgame_start (endgame_start),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .pix_index     (pix_index),
        .pix_valid     (pix_valid),
        .reveal_done   (reveal_done)
    );

`ifdef BG_ENDGAME_REVEAL_EN
    localparam logic DONE_RST = 1'b0;
    int m_state;
    int m_rows;
`else
    localparam logic DONE_RST = 1'b1;
`endif

    typedef struct {
        int         due;
        logic [16:0] addr;
        logic [3:0]  pix;
        logic        vld;
    } exp_t;

    typedef struct {
        int   x;
        int   y;
        logic act;
        int   ea;
    } vec_t;

    exp_t        aq[$];
    exp_t        pq[$];
    vec_t        tbl[14];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [16:0] addr_prev;

    function automatic logic [3:0] rom_f(input logic [16:0] a);
        logic [3:0] v;
        v = a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
        if (v == 4'h5) v = 4'hA;
        return v;
    endfunction

    function automatic int model_addr(input int x, input int y, input logic act);
        if (!act) return 0;
        return (y / 2) * 320 + (x / 2);
    endfunction

    function automatic logic exp_done();
`ifdef BG_ENDGAME_REVEAL_EN
        return m_state == 2;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // One pixel clock: check what is due, emulate the sync ROM, drive the next pixel.
    task automatic step(input int x, input int y, input logic act, input logic st, input int ea);
        exp_t e;
        logic rv;
        @(negedge vga_clk);
        cyc++;
        check("reveal_done", reveal_done, exp_done());
        while (aq.size() > 0 && aq[0].due == cyc) begin
            e = aq.pop_front();
            check("rom_addr", rom_addr, e.addr);
        end
        while (pq.size() > 0 && pq[0].due == cyc) begin
            e = pq.pop_front();
            check("pix_index", pix_index, e.pix);
            check("pix_valid", pix_valid, e.vld);
        end
        rom_q     = rom_f(addr_prev);
        addr_prev = rom_addr;
        DrawX         = 10'(x);
        DrawY         = 10'(y);
        active        = act;
        endgame_start = st;
        rv = 1'b1;
`ifdef BG_ENDGAME_REVEAL_EN
        if (m_state == 0) begin
            if (st) m_state = 1;
        end else if (m_state == 1 && x == 0 && y == 0) begin
            m_rows += 8;
            if (m_rows >= 480) begin
                m_rows  = 480;
                m_state = 2;
            end
        end
        rv = (y < m_rows);
`endif
        aq.push_back('{due: cyc + 1, addr: 17'(ea), pix: 4'h0, vld: 1'b0});
        pq.push_back('{due: cyc + 3, addr: 17'd0,
                       pix: (act && rv) ? rom_f(17'(ea)) : 4'h5, vld: act});
    endtask

    task automatic pix(input int x, input int y, input logic act);
        step(x, y, act, 1'b0, model_addr(x, y, act));
    endtask

    task automatic pulse_start();
        step(10, 10, 1'b1, 1'b1, model_addr(10, 10, 1'b1));
    endtask

    // Two blanking cycles drain in-flight pixels before the frame-start pixel.
    task automatic frame_start();
        step(700, 500, 1'b0, 1'b0, 0);
        step(700, 500, 1'b0, 1'b0, 0);
        step(0, 0, 1'b1, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pix_index", pix_index, 4'h5);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_reveal_done", reveal_done, DONE_RST);
        aq.delete();
        pq.delete();
        addr_prev     = '0;
        rom_q         = '0;
        DrawX         = 10'd700;
        DrawY         = 10'd500;
        active        = 1'b0;
        endgame_start = 1'b0;
`ifdef BG_ENDGAME_REVEAL_EN
        m_state = 0;
        m_rows  = 0;
`endif
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int x, y;
        reset_n       = 1'b0;
        DrawX         = '0;
        DrawY         = '0;
        active        = 1'b0;
        endgame_start = 1'b0;
        rom_q         = '0;
        addr_prev     = '0;
`ifdef BG_ENDGAME_REVEAL_EN
        m_state = 0;
        m_rows  = 0;
`endif
        tbl[0]  = '{3,   5,   1'b1, 641};
        tbl[1]  = '{639, 479, 1'b1, 76799};
        tbl[2]  = '{700, 5,   1'b0, 0};
        tbl[3]  = '{0,   0,   1'b1, 0};
        tbl[4]  = '{1,   1,   1'b1, 0};
        tbl[5]  = '{2,   0,   1'b1, 1};
        tbl[6]  = '{0,   2,   1'b1, 320};
        tbl[7]  = '{639, 0,   1'b1, 319};
        tbl[8]  = '{0,   479, 1'b1, 76480};
        tbl[9]  = '{100, 200, 1'b1, 32050};
        tbl[10] = '{320, 240, 1'b1, 38560};
        tbl[11] = '{5,   520, 1'b0, 0};
        tbl[12] = '{638, 478, 1'b1, 76799};
        tbl[13] = '{641, 10,  1'b0, 0};

        do_reset();

        for (int i = 0; i < 14; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].act, 1'b0, tbl[i].ea);

        // Reset lands while the pipeline holds visible pixels.
        step(3, 5, 1'b1, 1'b0, 641);
        step(639, 479, 1'b1, 1'b0, 76799);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
            pix(x, y, (x < 640) && (y < 480));
        end

`ifndef BG_ENDGAME_REVEAL_EN
        pulse_start();
        frame_start();
        pix(20, 0, 1'b1);
        pix(20, 8, 1'b1);
        frame_start();
        pix(639, 479, 1'b1);
        pix(100, 300, 1'b1);
`else
        // First band, then the full 60-frame wipe.
        do_reset();
        pix(10, 10, 1'b1);
        pulse_start();
        pix(10, 10, 1'b1);
        frame_start();
        pix(20, 6, 1'b1);
        pix(20, 7, 1'b1);
        pix(20, 8, 1'b1);
        pix(20, 9, 1'b1);
        pix(639, 7, 1'b1);
        pix(639, 8, 1'b1);
        for (int f = 2; f <= 60; f++) begin
            frame_start();
            pix(30, m_rows - 1, 1'b1);
            if (m_rows < 480) pix(30, m_rows, 1'b1);
        end
        pix(0, 0, 1'b1);
        pix(200, 240, 1'b1);
        pix(639, 479, 1'b1);
        pulse_start();
        frame_start();
        pix(5, 479, 1'b1);
        pix(700, 479, 1'b0);

        // Reset partway through the wipe, then restart from zero rows.
        do_reset();
        pulse_start();
        for (int f = 1; f <= 30; f++) frame_start();
        pix(40, 100, 1'b1);
        pix(40, 239, 1'b1);
        pix(40, 240, 1'b1);
        do_reset();
        pix(40, 0, 1'b1);
        pix(40, 100, 1'b1);
        pix(639, 479, 1'b1);
        frame_start();
        pix(40, 0, 1'b1);
        pulse_start();
        frame_start();
        pix(40, 7, 1'b1);
        pix(40, 8, 1'b1);

        // Start pulse coincident with the frame start in IDLE: no increment yet.
        do_reset();
        step(700, 500, 1'b0, 1'b0, 0);
        step(700, 500, 1'b0, 1'b0, 0);
        step(0, 0, 1'b1, 1'b1, 0);
        pix(40, 0, 1'b1);
        pix(40, 7, 1'b1);
        frame_start();
        pix(40, 7, 1'b1);
        pix(40, 8, 1'b1);
`endif

        for (int i = 0; i < 4; i++) step(700, 500, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
